cla_adder_pipe: RTL

Parametrised, pipelined carry-lookahead adder for the FPU datapath: mantissa/exponent adds of arbitrary width at one result per cycle. Operands are split into BLOCK-bit lookahead groups and one group is resolved per pipeline stage, with the group carry registered between stages. A valid/ready handshake with full-pipeline stall lets the block sit between the FPU alignment and normalisation stages.

---
 rtl/cla_pkg.sv | 24 ++
 rtl/cla_block.sv | 43 ++++
 rtl/cla_adder_pipe.sv | 115 +++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// Default configuration: 32-bit operands resolved in 8-bit lookahead groups.
package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_BLOCK = 8;

  // Number of pipeline stages: one lookahead group per stage.
  function automatic int cla_nstage(input int width, input int block);
    return (block < 1) ? 1 : width / block;
  endfunction

  // Stage record layout for the default width. The top declares the same
  // layout locally so it can follow its WIDTH parameter.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 ovf;
    logic [CLA_WIDTH-1:0] psum;
    logic [CLA_WIDTH-1:0] a;
    logic [CLA_WIDTH-1:0] b;
  } cla_stage_t;

endpackage

// File: rtl/cla_block.sv
// One BLOCK-bit carry-lookahead group (purely combinational).
// Every internal carry is expanded from generate/propagate terms and the
// group carry-in, so no carry ripples bit-to-bit inside the group.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign g = a_i & b_i;
  assign p = a_i | b_i;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    logic pp;
    c    = '0;
    pp   = 1'b0;
    c[0] = cin_i;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin_i);
    end
  end

  assign sum_o  = a_i ^ b_i ^ c[BLOCK-1:0];
  assign cout_o = c[BLOCK];
  assign cmsb_o = c[BLOCK-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder: one BLOCK-bit group resolved per stage,
// group carry registered between stages, one result per cycle.
// Optional feature macro: CLA_PIPE_SUB_EN adds the 'sub' port (a - b).
//
// Handshake: a beat is accepted when in_valid && in_ready; a result is
// consumed when out_valid && out_ready. The whole pipeline advances on
// en = !out_valid || out_ready (in_ready = en); when en is low every stage,
// valid bits included, holds. Bubbles are not collapsed.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = cla_nstage(WIDTH, BLOCK);

  if ((BLOCK < 1) || ((WIDTH % BLOCK) != 0)) begin : g_cfg_err
    $fatal(1, "cla_adder_pipe: WIDTH must be a positive multiple of BLOCK");
  end

  // Same field order as cla_pkg::cla_stage_t, sized by WIDTH.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           st_q [NSTAGE];
  stage_t           st_d [NSTAGE];
  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction only touches stage 0: b is inverted and the carry-in forced
  // to 1, after which the pipeline is an ordinary adder.
`ifdef CLA_PIPE_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    logic [BLOCK-1:0] grp_sum;
    logic             grp_cout;
    logic             grp_cmsb;

    if (k == 0) begin : g_first
      assign src = '{valid: in_valid, carry: cin_eff, ovf: 1'b0,
                     psum: '0, a: a, b: b_eff};
    end else begin : g_next
      assign src = st_q[k-1];
    end

    cla_block #(.BLOCK(BLOCK)) u_blk (
      .a_i    (src.a[k*BLOCK +: BLOCK]),
      .b_i    (src.b[k*BLOCK +: BLOCK]),
      .cin_i  (src.carry),
      .sum_o  (grp_sum),
      .cout_o (grp_cout),
      .cmsb_o (grp_cmsb)
    );

    // Insert this group's sum bits and forward its carry; overflow is only
    // meaningful in the last stage, where the group holds the MSB.
    always_comb begin
      nxt                       = src;
      nxt.psum[k*BLOCK +: BLOCK] = grp_sum;
      nxt.carry                 = grp_cout;
      nxt.ovf                   = grp_cmsb ^ grp_cout;
    end

    assign st_d[k] = nxt;
  end

  // Stage registers: cleared on reset, all advance together on en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGE; k++) st_q[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < NSTAGE; k++) st_q[k] <= st_d[k];
    end
  end

  assign out_valid = st_q[NSTAGE-1].valid;
  assign sum       = st_q[NSTAGE-1].psum;
  assign cout      = st_q[NSTAGE-1].carry;
  assign ovf       = st_q[NSTAGE-1].ovf;
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

endmodule
